// File: rtl/activation_pkg.sv
// Shared definitions for the activation stream: mode codes, FSM states and
// IEEE-754 field helpers. The helpers take field widths as arguments, so they
// work for any EXP_WIDTH/MANT_WIDTH combination up to a 64-bit word.
package activation_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_LEAKY  = 2'd2,
        MODE_CLIP   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic word_sign(input logic [63:0] w, input int ew, input int mw);
        return w[ew + mw];
    endfunction

    function automatic logic [63:0] word_exp(input logic [63:0] w, input int ew, input int mw);
        return (w >> mw) & ((64'd1 << ew) - 64'd1);
    endfunction

    function automatic logic [63:0] word_mant(input logic [63:0] w, input int mw);
        return w & ((64'd1 << mw) - 64'd1);
    endfunction

endpackage

// File: rtl/activation_stream_if.sv
// Vector handshake bundle: input vector with its mode/clip settings, and the
// activated result with its zero count. The block uses the slave view.
interface activation_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NODES      = 32
);
    localparam int COUNT_WIDTH = $clog2(NODES + 1);

    logic [1:0]                  mode;
    logic [DATA_WIDTH-1:0]       clip_value;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH*NODES-1:0] input_fc;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH*NODES-1:0] output_fc;
    logic [COUNT_WIDTH-1:0]      zero_count;

    modport master (
        output mode, clip_value, in_valid, input_fc, out_ready,
        input  in_ready, out_valid, output_fc, zero_count
    );

    modport slave (
        input  mode, clip_value, in_valid, input_fc, out_ready,
        output in_ready, out_valid, output_fc, zero_count
    );
endinterface

// File: rtl/activation_lane.sv
// One combinational activation lane: applies the selected function to a
// single IEEE-754 word and flags an all-zero result.
module activation_lane
    import activation_pkg::*;
#(
    parameter int  EXP_WIDTH  = 8,
    parameter int  MANT_WIDTH = 23,
    parameter int  LEAK_SHIFT = 3,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  mode_t                 mode,
    input  logic [DATA_WIDTH-1:0] clip_value,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  is_zero
);
    localparam logic [EXP_WIDTH-1:0]  LEAK_E   = EXP_WIDTH'(LEAK_SHIFT);
    localparam logic [DATA_WIDTH-1:0] MAG_MASK = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic                  s;
    logic [EXP_WIDTH-1:0]  e;
    logic [MANT_WIDTH-1:0] m;
    logic [DATA_WIDTH-1:0] clip_mag;

    assign s        = word_sign(64'(x), EXP_WIDTH, MANT_WIDTH);
    assign e        = EXP_WIDTH'(word_exp(64'(x), EXP_WIDTH, MANT_WIDTH));
    assign m        = MANT_WIDTH'(word_mant(64'(x), MANT_WIDTH));
    // Clip threshold is always treated as a positive magnitude.
    assign clip_mag = clip_value & MAG_MASK;

    // Per-word activation; negative Inf/NaN pass leaky mode untouched.
    always_comb begin
        y = x;
        case (mode)
            MODE_RELU: begin
                if (s) y = '0;
            end
            MODE_LEAKY: begin
                if (s && (e != '1)) begin
                    if (e > LEAK_E) y = {1'b1, e - LEAK_E, m};
                    else            y = '0;
                end
            end
            MODE_CLIP: begin
                if (s)                          y = '0;
                else if ((x & MAG_MASK) > clip_mag) y = clip_mag;
            end
            default: y = x;
        endcase
    end

    assign is_zero = (y == '0);

endmodule

// File: rtl/activation_stream.sv
// Lane-serialised activation stage: captures one vector, runs it through
// LANES activation lanes per cycle, then holds the result and its zero count
// until the consumer takes it.
module activation_stream
    import activation_pkg::*;
#(
    parameter int  EXP_WIDTH   = 8,
    parameter int  MANT_WIDTH  = 23,
    parameter int  NODES       = 32,
    parameter int  LANES       = 4,
    parameter int  LEAK_SHIFT  = 3,
    localparam int DATA_WIDTH  = 1 + EXP_WIDTH + MANT_WIDTH,
    localparam int GROUPS      = NODES / LANES,
    localparam int GW          = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int COUNT_WIDTH = $clog2(NODES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    activation_stream_if.slave bus
);
    if (NODES % LANES != 0) begin : g_bad_lanes
        $error("NODES must be a multiple of LANES");
    end
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > (1 << EXP_WIDTH) - 2) begin : g_bad_leak
        $error("LEAK_SHIFT out of range");
    end

    state_t                      state, state_next;
    logic [GW-1:0]               g;
    logic [DATA_WIDTH*NODES-1:0] vec_r;
    logic [DATA_WIDTH*NODES-1:0] out_r;
    mode_t                       mode_r;
    logic [DATA_WIDTH-1:0]       clip_r;
    logic [COUNT_WIDTH-1:0]      zc_r;
    logic [DATA_WIDTH-1:0]       lane_in  [LANES];
    logic [DATA_WIDTH-1:0]       lane_out [LANES];
    logic [LANES-1:0]            lane_zero;
    logic [COUNT_WIDTH-1:0]      hits;
    logic                        accept;
    logic                        last_group;

    assign accept     = bus.in_valid && (state == IDLE);
    assign last_group = (g == GW'(GROUPS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: fixed-length RUN, then hold in DONE until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_group) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select the current group's words from the captured vector.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = vec_r[DATA_WIDTH*(int'(g)*LANES + l) +: DATA_WIDTH];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        activation_lane #(
            .EXP_WIDTH  (EXP_WIDTH),
            .MANT_WIDTH (MANT_WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x          (lane_in[l]),
            .mode       (mode_r),
            .clip_value (clip_r),
            .y          (lane_out[l]),
            .is_zero    (lane_zero[l])
        );
    end

    // Count zero results produced by this group.
    always_comb begin
        hits = '0;
        for (int l = 0; l < LANES; l++) begin
            hits = hits + COUNT_WIDTH'(lane_zero[l]);
        end
    end

    // Capture on accept; write one group of results per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            g     <= '0;
            out_r <= '0;
            zc_r  <= '0;
        end else if (accept) begin
            vec_r  <= bus.input_fc;
            mode_r <= mode_t'(bus.mode);
            clip_r <= bus.clip_value;
            zc_r   <= '0;
            g      <= '0;
        end else if (state == RUN) begin
            for (int l = 0; l < LANES; l++) begin
                out_r[DATA_WIDTH*(int'(g)*LANES + l) +: DATA_WIDTH] <= lane_out[l];
            end
            zc_r <= zc_r + hits;
            g    <= last_group ? '0 : g + GW'(1);
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.output_fc  = out_r;
    assign bus.zero_count = zc_r;

endmodule

// File: tb/tb_activation_stream.sv
// Randomised self-checking bench for activation_stream with a transaction
// level reference model and a per-cycle compare process.
module tb_activation_stream;
    localparam int DW    = 32;
    localparam int NODES = 32;
    localparam int LANES = 4;
    localparam int LEAK  = 3;
    localparam int G     = NODES / LANES;
    localparam int VW    = DW * NODES;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    activation_stream_if #(.DATA_WIDTH(DW), .NODES(NODES)) bus ();

    activation_stream #(
        .EXP_WIDTH(8), .MANT_WIDTH(23), .NODES(NODES), .LANES(LANES), .LEAK_SHIFT(LEAK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference activation of one float32 word.
    function automatic logic [31:0] act(input logic [31:0] x, input logic [1:0] md, input logic [31:0] clip);
        int e;
        e = int'(x[30:23]);
        case (md)
            2'd0: return x;
            2'd1: return x[31] ? 32'h0 : x;
            2'd2: begin
                if (!x[31] || e == 255) return x;
                if (e > LEAK) return x - (32'(LEAK) << 23);  // scale by 2^-LEAK
                return 32'h0;
            end
            default: begin
                if (x[31]) return 32'h0;
                if (x[30:0] > clip[30:0]) return {1'b0, clip[30:0]};
                return x;
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 9))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'hFF800000;
            3: return 32'h7FC00000;
            4: return 32'hFFC00001;
            5: return {1'b1, 8'(LEAK), 23'($urandom)};
            6: return {1'b1, 8'(LEAK + 1), 23'($urandom)};
            7: return {1'b1, 8'h00, 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NODES; i++) v[DW*i +: DW] = rand_word();
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Transaction-level model: a whole vector's result is computed at accept.
    logic [VW-1:0] m_vec;
    int            m_zc;
    int            m_cnt   = 0;
    bit            m_done  = 0;
    bit            m_fresh = 0;
    bit            started = 0;

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            m_cnt = 0; m_done = 0; m_fresh = 1;
        end else if (!m_done && m_cnt == 0 && bus.in_valid) begin
            m_zc = 0;
            for (int i = 0; i < NODES; i++) begin
                m_vec[DW*i +: DW] = act(bus.input_fc[DW*i +: DW], bus.mode, bus.clip_value);
                if (m_vec[DW*i +: DW] == 32'h0) m_zc++;
            end
            m_cnt = G; m_fresh = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1;
        end else if (m_done && bus.out_ready) begin
            m_done = 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!m_done && m_cnt == 0));
            chk("out_valid", 32'(bus.out_valid), 32'(m_done));
            if (m_done) begin
                chk_vec("output_fc", bus.output_fc, m_vec);
                chk("zero_count", 32'(bus.zero_count), 32'(m_zc));
            end
            if (m_fresh) begin
                chk_vec("reset_output_fc", bus.output_fc, '0);
                chk("reset_zero_count", 32'(bus.zero_count), 32'h0);
            end
        end
    end

    task automatic send(input logic [VW-1:0] v, input logic [1:0] md, input logic [31:0] cl);
        int n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("send_timeout", 32'(bus.in_ready), 32'h1);
        bus.input_fc = v; bus.mode = md; bus.clip_value = cl; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.input_fc   = rand_vec();
        bus.mode       = 2'($urandom);
        bus.clip_value = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
        if (lat >= 100) chk("out_valid_timeout", 32'(bus.out_valid), 32'h1);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] word(input int i);
        return bus.output_fc[DW*i +: DW];
    endfunction

    logic [VW-1:0] v;
    int            lat;

    initial begin
        reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.mode = 2'd0; bus.clip_value = '0; bus.input_fc = '0;

        // Pin the model with hand-computed values.
        chk("model_leaky", act(32'hBF800000, 2'd2, 32'h0), 32'hBE000000);
        chk("model_denorm", act(32'h80000001, 2'd2, 32'h0), 32'h00000000);
        chk("model_clip", act(32'h40E00000, 2'd3, 32'h40C00000), 32'h40C00000);
        chk("model_relu", act(32'hBF800000, 2'd1, 32'h0), 32'h00000000);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ReLU on alternating +1/-1.
        for (int i = 0; i < NODES; i++) v[DW*i +: DW] = (i % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
        send(v, 2'd1, 32'h0);
        wait_valid(lat);
        chk("relu_latency", 32'(lat), 32'd8);
        chk("relu_even", word(0), 32'h3F800000);
        chk("relu_odd", word(1), 32'h00000000);
        chk("relu_zc", 32'(bus.zero_count), 32'd16);
        take();

        // Leaky ReLU corner words.
        v = rand_vec();
        v[31:0] = 32'hBF800000; v[63:32] = 32'h80000001; v[95:64] = 32'hFF800000;
        send(v, 2'd2, 32'h0);
        wait_valid(lat);
        chk("leaky_neg1", word(0), 32'hBE000000);
        chk("leaky_denorm", word(1), 32'h00000000);
        chk("leaky_ninf", word(2), 32'hFF800000);
        take();

        // Clipped ReLU at 6.0.
        v = rand_vec();
        v[31:0] = 32'h40E00000; v[63:32] = 32'h40A00000; v[95:64] = 32'hC0000000;
        send(v, 2'd3, 32'h40C00000);
        wait_valid(lat);
        chk("clip_7", word(0), 32'h40C00000);
        chk("clip_5", word(1), 32'h40A00000);
        chk("clip_neg2", word(2), 32'h00000000);
        take();

        // Bypass: only +0 counts as zero.
        for (int i = 0; i < NODES; i++) v[DW*i +: DW] = $urandom | 32'h1;
        v[31:0] = 32'h80000000; v[63:32] = 32'h00000000;
        send(v, 2'd0, 32'h0);
        wait_valid(lat);
        chk("bypass_negzero", word(0), 32'h80000000);
        chk("bypass_zc", 32'(bus.zero_count), 32'd1);
        take();

        // Backpressure with in_valid held during DONE.
        send(rand_vec(), 2'd2, 32'h0);
        wait_valid(lat);
        bus.in_valid = 1'b1; bus.input_fc = rand_vec(); bus.mode = 2'd1;
        repeat (5) @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_idle", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_accepted", 32'(bus.in_ready), 32'h0);
        wait_valid(lat);
        take();

        // Reset in the middle of RUN at group 3.
        send(rand_vec(), 2'd1, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_zc", 32'(bus.zero_count), 32'h0);
        chk_vec("rst_output", bus.output_fc, '0);
        send(rand_vec(), 2'd2, 32'h0);
        wait_valid(lat);
        chk("rst_fresh_latency", 32'(lat), 32'd8);
        take();

        // Randomised traffic.
        for (int k = 0; k < 40; k++) begin
            bus.out_ready = 1'($urandom);
            send(rand_vec(), 2'($urandom), {1'b0, 31'($urandom)});
            wait_valid(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take();
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
